picorv32_ahb_bridge_v2: RTL and testbench
=========================================

// Module: picorv32_ahb_bridge_v2
// PURPOSE
//  Parametrised second-generation bridge from the PicoRV32 native memory interface to the FreeAHB master.
//  Reads become one word transfer. Writes are split into byte, halfword or word AHB transfers according to mem_wstrb.
//  Adds selectable lane order, a bus timeout with an error flag, and registered read data.
//  Sits between the picorv32 core and the FreeAHB master inside the GRLIB AHB wrapper.
// PARAMETERS
//  ADDR_W      32        address width; mem_addr and freeahb_addr
//  BIG_ENDIAN  1         1: wstrb[i] maps to byte addr+(3-i); 0: wstrb[i] maps to byte addr+i
//  TIMEOUT     1023      cycles without progress before abort; 0 disables the timeout
//  ERR_RDATA   32'hDEAD_BEEF  read data returned on a timeout
// PORTS
//  clk              in   1       clock
//  rst              in   1       asynchronous reset, active-high
//  mem_valid        in   1       PicoRV32 request valid
//  mem_instr        in   1       instruction fetch
//  mem_addr         in   ADDR_W  byte address, word aligned
//  mem_wdata        in   32      write data
//  mem_wstrb        in   4       byte write strobes; 0 = read
//  mem_ready        out  1       one-cycle completion pulse
//  mem_rdata        out  32      registered read data
//  mem_err          out  1       high together with mem_ready when the request timed out
//  freeahb_valid    out  1       transfer request
//  freeahb_addr     out  ADDR_W  transfer address
//  freeahb_size     out  3       0 = byte, 1 = halfword, 2 = word
//  freeahb_write    out  1       write transfer
//  freeahb_read     out  1       read transfer
//  freeahb_wdata    out  32      write data, lane-positioned per BIG_ENDIAN
//  freeahb_min_len  out  32      always 1
//  freeahb_cont     out  1       always 0
//  freeahb_prot     out  4       4'b0000 if mem_instr, else 4'b0001
//  freeahb_lock     out  1       high from the first beat to the last beat of a write sequence
//  freeahb_next     in   1       beat accepted / previous data phase done
//  freeahb_rdata    in   32      read data
//  freeahb_ready    in   1       freeahb_rdata valid
// BEHAVIOUR
//  Reset: every output is 0 except freeahb_min_len = 1. FSM goes to IDLE and the counters clear.
//  FSM states: IDLE, RD_REQ, RD_WAIT, WR_PLAN, WR_REQ, WR_DRAIN, DONE.
//  IDLE:
//   - mem_valid with wstrb == 0 -> RD_REQ.
//   - mem_valid with wstrb != 0 -> WR_PLAN; mem_addr, mem_wdata and mem_wstrb are latched.
//   - mem_valid with wstrb == 0 is ignored unless the FSM is in IDLE.
//  RD_REQ: freeahb_valid = 1, read, size = 2. On freeahb_next -> RD_WAIT and freeahb_valid drops.
//  RD_WAIT: on freeahb_ready, mem_rdata <= freeahb_rdata -> DONE.
//   - mem_ready is asserted one cycle after freeahb_ready.
//  WR_PLAN: pick the lowest-address pending chunk, then -> WR_REQ.
//   - Chunks are issued in ascending address order.
//   - Each chunk's strobes clear when freeahb_next accepts it.
//  WR_REQ: drive the chunk.
//   - On freeahb_next: if strobes remain -> WR_PLAN, else -> WR_DRAIN.
//  WR_DRAIN: wait for freeahb_next (last data phase done) -> DONE.
//  DONE: pulse mem_ready for 1 cycle -> IDLE.
//   - The bridge ignores mem_valid for that cycle; PicoRV32 drops or renews it.
//  Timeout counter:
//   - Counts in every state other than IDLE and DONE.
//   - Clears on each freeahb_next or freeahb_ready.
//   - Reaching TIMEOUT: freeahb_valid <= 0, mem_rdata <= ERR_RDATA, mem_err = 1 -> DONE.
//  Addresses:
//   - Chunk address = latched mem_addr + byte offset, computed modulo 2^ADDR_W.
//   - Bits [1:0] of mem_addr are ignored.
//  mem_valid falling mid-operation does not abort; the sequence completes and mem_ready still pulses.
//  rst mid-operation clears everything at once; no partial write is retried.
// CONFIGURATION
//  PICORV_AHB_BRIDGE_MERGE_EN defined:
//   - wstrb 4'b1111 -> one word transfer.
//   - Each fully strobed aligned half (4'b0011 or 4'b1100, per lane order) -> one halfword transfer.
//   - Remaining strobes -> byte transfers.
//  PICORV_AHB_BRIDGE_MERGE_EN undefined: one byte transfer per set strobe, so a full word takes 4 beats.
// TESTING
//  Read, BIG_ENDIAN=1, addr 0x100, slave returns 0x12345678 two cycles after accept
//   -> mem_rdata = 0x12345678, mem_ready pulses once, mem_err = 0.
//  Write wstrb 4'b1111, wdata 0xAABBCCDD, MERGE_EN defined
//   -> 1 beat at 0x100, size 2, lock high during the sequence.
//  Same write, MERGE_EN undefined, BIG_ENDIAN=1
//   -> 4 byte beats at 0x100..0x103 carrying AA, BB, CC, DD in ascending address order.
//  Write wstrb 4'b1011, BIG_ENDIAN=0, MERGE_EN defined
//   -> halfword at 0x100, then byte at 0x103; mem_ready after the drain.
//  TIMEOUT=8 and freeahb_next held low for a read
//   -> after 8 cycles mem_ready and mem_err pulse, mem_rdata = 0xDEADBEEF.
//  Assert rst during the 2nd byte beat
//   -> all outputs return to reset values the same cycle; the next request starts clean.

Source files
------------

// File: rtl/picorv32_ahb_bridge_v2.sv
// picorv32_ahb_bridge_v2
//   Bridge from the PicoRV32 native memory interface to the FreeAHB master.
//   A read becomes one word transfer; a write is split into byte / halfword /
//   word transfers taken from mem_wstrb, issued in ascending address order.
//   A no-progress timeout aborts the request and flags mem_err.
//
// Build option:
//   PICORV_AHB_BRIDGE_MERGE_EN  when defined, a full word strobe becomes one
//                               word transfer and each fully strobed aligned
//                               half becomes one halfword transfer; when
//                               undefined every set strobe is one byte beat.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   mem_*             PicoRV32 side: request in, mem_ready pulse / rdata / err out
//   freeahb_*         FreeAHB master side: transfer request out, next/ready/rdata in
//   dbg_state         current FSM state, for observation only
//
// Handshake: a request is taken when mem_valid is seen in IDLE; it finishes
// with exactly one mem_ready cycle. A beat is held on freeahb_valid until
// freeahb_next accepts it; freeahb_next while draining means the last data
// phase is done; freeahb_ready qualifies freeahb_rdata for one cycle.
`timescale 1ns/1ps
module picorv32_ahb_bridge_v2 #(
    parameter int          ADDR_W     = 32,
    parameter bit          BIG_ENDIAN = 1'b1,
    parameter int          TIMEOUT    = 1023,
    parameter logic [31:0] ERR_RDATA  = 32'hDEAD_BEEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_valid,
    input  logic              mem_instr,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [31:0]       mem_wdata,
    input  logic [3:0]        mem_wstrb,
    output logic              mem_ready,
    output logic [31:0]       mem_rdata,
    output logic              mem_err,
    output logic              freeahb_valid,
    output logic [ADDR_W-1:0] freeahb_addr,
    output logic [2:0]        freeahb_size,
    output logic              freeahb_write,
    output logic              freeahb_read,
    output logic [31:0]       freeahb_wdata,
    output logic [31:0]       freeahb_min_len,
    output logic              freeahb_cont,
    output logic [3:0]        freeahb_prot,
    output logic              freeahb_lock,
    input  logic              freeahb_next,
    input  logic [31:0]       freeahb_rdata,
    input  logic              freeahb_ready,
    output logic [2:0]        dbg_state
);

    typedef enum logic [2:0] {
        IDLE, RD_REQ, RD_WAIT, WR_PLAN, WR_REQ, WR_DRAIN, DONE
    } state_t;

    localparam int             CNT_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam bit             TO_EN   = (TIMEOUT != 0);

    state_t            state, state_nx;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [3:0]        strb_q;
    logic              instr_q;
    logic [1:0]        chunk_off;
    logic [1:0]        chunk_size;
    logic [3:0]        chunk_mask;   // strobe-index space
    logic [CNT_W-1:0]  cnt;
    logic              err_q;
    logic [31:0]       rdata_q;

    logic [3:0]        pend_off;     // pending bytes indexed by address offset
    logic [1:0]        plan_off;
    logic [1:0]        plan_size;
    logic [3:0]        plan_off_mask;
    logic [3:0]        plan_strb;
    logic [31:0]       lane_mask;
    logic              active;
    logic              progress;
    logic              timeout_hit;

    // Byte at address offset k is carried by strobe / lane 3-k in big-endian
    // order and by lane k otherwise; for two bits 3-k is simply ~k.
    function automatic logic [1:0] lane_of(input logic [1:0] off);
        return BIG_ENDIAN ? ~off : off;
    endfunction

    // Chunk planner: lowest pending address first.
    always_comb begin
        pend_off      = '0;
        plan_off      = 2'd3;
        plan_size     = 2'd0;
        plan_off_mask = '0;
        plan_strb     = '0;
        for (int k = 0; k < 4; k++) begin
            pend_off[k] = strb_q[lane_of(2'(k))];
        end
        if (pend_off[0])      plan_off = 2'd0;
        else if (pend_off[1]) plan_off = 2'd1;
        else if (pend_off[2]) plan_off = 2'd2;
        plan_off_mask = 4'b0001 << plan_off;
`ifdef PICORV_AHB_BRIDGE_MERGE_EN
        if (pend_off == 4'b1111) begin
            plan_size     = 2'd2;
            plan_off_mask = 4'b1111;
        end else if (!plan_off[0] && pend_off[plan_off + 2'd1]) begin
            plan_size     = 2'd1;
            plan_off_mask = 4'b0011 << plan_off;
        end
`endif
        for (int k = 0; k < 4; k++) begin
            plan_strb[lane_of(2'(k))] = plan_off_mask[k];
        end
    end

    assign active      = (state != IDLE) && (state != DONE);
    assign progress    = freeahb_next || freeahb_ready;
    assign timeout_hit = TO_EN && active && !progress && (cnt == TO_LAST);

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:     if (mem_valid) state_nx = (mem_wstrb == 4'b0000) ? RD_REQ : WR_PLAN;
            RD_REQ:   if (freeahb_next) state_nx = RD_WAIT;
            RD_WAIT:  if (freeahb_ready) state_nx = DONE;
            WR_PLAN:  state_nx = WR_REQ;
            WR_REQ:   if (freeahb_next)
                          state_nx = ((strb_q & ~chunk_mask) != 4'b0000) ? WR_PLAN : WR_DRAIN;
            WR_DRAIN: if (freeahb_next) state_nx = DONE;
            DONE:     state_nx = IDLE;
            default:  state_nx = IDLE;
        endcase
        if (timeout_hit) state_nx = DONE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            addr_q     <= '0;
            wdata_q    <= '0;
            strb_q     <= '0;
            instr_q    <= 1'b0;
            chunk_off  <= '0;
            chunk_size <= '0;
            chunk_mask <= '0;
            err_q      <= 1'b0;
            rdata_q    <= '0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: if (mem_valid) begin
                    addr_q  <= mem_addr & ~ADDR_W'(3);
                    wdata_q <= mem_wdata;
                    strb_q  <= mem_wstrb;
                    instr_q <= mem_instr;
                    err_q   <= 1'b0;
                end
                WR_PLAN: begin
                    chunk_off  <= plan_off;
                    chunk_size <= plan_size;
                    chunk_mask <= plan_strb;
                end
                WR_REQ:  if (freeahb_next) strb_q <= strb_q & ~chunk_mask;
                RD_WAIT: if (freeahb_ready) rdata_q <= freeahb_rdata;
                default: ;
            endcase
            if (timeout_hit) begin
                rdata_q <= ERR_RDATA;
                err_q   <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                   cnt <= '0;
        else if (!active || progress || timeout_hit) cnt <= '0;
        else                       cnt <= cnt + CNT_W'(1);
    end

    always_comb begin
        for (int i = 0; i < 4; i++) lane_mask[8*i +: 8] = {8{chunk_mask[i]}};
    end

    always_comb begin
        freeahb_valid = 1'b0;
        freeahb_addr  = '0;
        freeahb_size  = 3'd0;
        freeahb_write = 1'b0;
        freeahb_read  = 1'b0;
        freeahb_wdata = '0;
        case (state)
            RD_REQ: begin
                freeahb_valid = 1'b1;
                freeahb_read  = 1'b1;
                freeahb_addr  = addr_q;
                freeahb_size  = 3'd2;
            end
            WR_REQ: begin
                freeahb_valid = 1'b1;
                freeahb_write = 1'b1;
                freeahb_addr  = addr_q + ADDR_W'(chunk_off);
                freeahb_size  = {1'b0, chunk_size};
                freeahb_wdata = wdata_q & lane_mask;
            end
            default: ;
        endcase
    end

    assign freeahb_lock    = (state == WR_PLAN) || (state == WR_REQ) || (state == WR_DRAIN);
    assign freeahb_prot    = (state == IDLE) ? 4'b0000 : {3'b000, ~instr_q};
    assign freeahb_min_len = 32'd1;
    assign freeahb_cont    = 1'b0;
    assign mem_ready       = (state == DONE);
    assign mem_err         = (state == DONE) && err_q;
    assign mem_rdata       = rdata_q;
    assign dbg_state       = state;

endmodule

// File: tb/tb_picorv32_ahb_bridge_v2.sv
`timescale 1ns/1ps
module tb_picorv32_ahb_bridge_v2;

  localparam int TO = 8;

  typedef struct packed {
    logic [31:0] addr;
    logic [2:0]  size;
    logic [31:0] data;
    logic [31:0] mask;
  } beat_t;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // per-instance signals: [0] big-endian, [1] little-endian
  logic        mem_valid [2];
  logic        mem_instr [2];
  logic [31:0] mem_addr  [2];
  logic [31:0] mem_wdata [2];
  logic [3:0]  mem_wstrb [2];
  logic        mem_ready [2];
  logic [31:0] mem_rdata [2];
  logic        mem_err   [2];
  logic        fa_valid  [2];
  logic [31:0] fa_addr   [2];
  logic [2:0]  fa_size   [2];
  logic        fa_write  [2];
  logic        fa_read   [2];
  logic [31:0] fa_wdata  [2];
  logic [31:0] fa_min_len[2];
  logic        fa_cont   [2];
  logic [3:0]  fa_prot   [2];
  logic        fa_lock   [2];
  logic        fa_next   [2];
  logic [31:0] fa_rdata  [2];
  logic        fa_ready  [2];
  logic [2:0]  dbg_state [2];

  picorv32_ahb_bridge_v2 #(.ADDR_W(32), .BIG_ENDIAN(1'b1), .TIMEOUT(TO)) dut_be (
    .clk(clk), .rst(rst),
    .mem_valid(mem_valid[0]), .mem_instr(mem_instr[0]), .mem_addr(mem_addr[0]),
    .mem_wdata(mem_wdata[0]), .mem_wstrb(mem_wstrb[0]), .mem_ready(mem_ready[0]),
    .mem_rdata(mem_rdata[0]), .mem_err(mem_err[0]),
    .freeahb_valid(fa_valid[0]), .freeahb_addr(fa_addr[0]), .freeahb_size(fa_size[0]),
    .freeahb_write(fa_write[0]), .freeahb_read(fa_read[0]), .freeahb_wdata(fa_wdata[0]),
    .freeahb_min_len(fa_min_len[0]), .freeahb_cont(fa_cont[0]), .freeahb_prot(fa_prot[0]),
    .freeahb_lock(fa_lock[0]), .freeahb_next(fa_next[0]), .freeahb_rdata(fa_rdata[0]),
    .freeahb_ready(fa_ready[0]), .dbg_state(dbg_state[0])
  );

  picorv32_ahb_bridge_v2 #(.ADDR_W(32), .BIG_ENDIAN(1'b0), .TIMEOUT(TO)) dut_le (
    .clk(clk), .rst(rst),
    .mem_valid(mem_valid[1]), .mem_instr(mem_instr[1]), .mem_addr(mem_addr[1]),
    .mem_wdata(mem_wdata[1]), .mem_wstrb(mem_wstrb[1]), .mem_ready(mem_ready[1]),
    .mem_rdata(mem_rdata[1]), .mem_err(mem_err[1]),
    .freeahb_valid(fa_valid[1]), .freeahb_addr(fa_addr[1]), .freeahb_size(fa_size[1]),
    .freeahb_write(fa_write[1]), .freeahb_read(fa_read[1]), .freeahb_wdata(fa_wdata[1]),
    .freeahb_min_len(fa_min_len[1]), .freeahb_cont(fa_cont[1]), .freeahb_prot(fa_prot[1]),
    .freeahb_lock(fa_lock[1]), .freeahb_next(fa_next[1]), .freeahb_rdata(fa_rdata[1]),
    .freeahb_ready(fa_ready[1]), .dbg_state(dbg_state[1])
  );

  // scoreboard
  int    checks   = 0;
  int    failures = 0;
  beat_t exp_q[$];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // reference model: expected write beats from the lane and merge rules
  function automatic bit merge_on();
`ifdef PICORV_AHB_BRIDGE_MERGE_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  function automatic int lane(input int u, input int off);
    return (u == 0) ? 3 - off : off;
  endfunction

  task automatic push_beat(input int u, input logic [31:0] base, input logic [31:0] wdata,
                           input int off, input int nbytes, input logic [2:0] size);
    beat_t b;
    b.addr = base + off;
    b.size = size;
    b.data = '0;
    b.mask = '0;
    for (int j = off; j < off + nbytes; j++) begin
      b.mask[8*lane(u, j) +: 8] = 8'hFF;
      b.data[8*lane(u, j) +: 8] = wdata[8*lane(u, j) +: 8];
    end
    exp_q.push_back(b);
  endtask

  task automatic plan_beats(input int u, input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [3:0] wstrb);
    logic [31:0] base;
    bit          have [4];
    int          k;
    base = addr & ~32'd3;
    for (int j = 0; j < 4; j++) have[j] = wstrb[lane(u, j)];
    if (merge_on() && wstrb == 4'hF) begin
      push_beat(u, base, wdata, 0, 4, 3'd2);
    end else begin
      k = 0;
      while (k < 4) begin
        if (!have[k]) k++;
        else if (merge_on() && (k % 2 == 0) && have[k+1]) begin
          push_beat(u, base, wdata, k, 2, 3'd1);
          k += 2;
        end else begin
          push_beat(u, base, wdata, k, 1, 3'd0);
          k++;
        end
      end
    end
  endtask

  task automatic check_reset(input int u, input string tag);
    check_eq({tag, "_flags"}, {mem_ready[u], mem_err[u], fa_valid[u], fa_write[u],
                               fa_read[u], fa_cont[u], fa_lock[u]}, 0);
    check_eq({tag, "_rdata"}, mem_rdata[u], 0);
    check_eq({tag, "_addr"}, fa_addr[u], 0);
    check_eq({tag, "_wdata"}, fa_wdata[u], 0);
    check_eq({tag, "_size_prot"}, {fa_size[u], fa_prot[u]}, 0);
    check_eq({tag, "_min_len"}, fa_min_len[u], 1);
    check_eq({tag, "_state"}, dbg_state[u], 0);
  endtask

  // driver + slave responder for one request; drop_at > 0 lowers mem_valid early
  task automatic run_txn(input int u, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] wstrb, input logic instr, input logic [31:0] rdata,
                         input int lat, input bit hang, input int drop_at);
    int    cyc, stall, rd_cd, rdy_cyc;
    bit    done;
    beat_t b;
    exp_q.delete();
    if (wstrb != 4'b0000) plan_beats(u, addr, wdata, wstrb);
    @(negedge clk);
    mem_valid[u] = 1'b1;
    mem_addr[u]  = addr;
    mem_wdata[u] = wdata;
    mem_wstrb[u] = wstrb;
    mem_instr[u] = instr;
    stall   = $urandom_range(0, 3);
    rd_cd   = -1;
    rdy_cyc = -10;
    cyc     = 0;
    done    = 1'b0;
    while (!done && cyc < 200) begin
      fa_next[u]  = 1'b0;
      fa_ready[u] = 1'b0;
      if (!hang) begin
        if (stall == 0) begin
          fa_next[u] = 1'b1;
          stall = $urandom_range(0, 3);
        end else stall--;
        if (rd_cd == 0) begin
          fa_ready[u] = 1'b1;
          fa_rdata[u] = rdata;
          rdy_cyc     = cyc;
          rd_cd       = -1;
        end else if (rd_cd > 0) rd_cd--;
      end
      if (fa_valid[u] && fa_next[u]) begin
        if (fa_read[u]) begin
          check_eq("rd_addr", fa_addr[u], addr & ~32'd3);
          check_eq("rd_size_write_lock", {fa_size[u], fa_write[u], fa_lock[u]}, {3'd2, 2'b00});
          check_eq("rd_prot", fa_prot[u], {3'b000, ~instr});
          rd_cd = lat;
        end else if (exp_q.size() == 0) begin
          check_eq("extra_beat", 1, 0);
        end else begin
          b = exp_q.pop_front();
          check_eq("beat_addr", fa_addr[u], b.addr);
          check_eq("beat_size", fa_size[u], b.size);
          check_eq("beat_data", fa_wdata[u] & b.mask, b.data);
          check_eq("beat_lock_prot", {fa_lock[u], fa_prot[u]}, {1'b1, 3'b000, ~instr});
        end
      end
      @(negedge clk);
      cyc++;
      if (cyc == drop_at) mem_valid[u] = 1'b0;
      if (mem_ready[u]) done = 1'b1;
    end
    fa_next[u]  = 1'b0;
    fa_ready[u] = 1'b0;
    if (!done) begin
      check_eq("mem_ready_timeout", 0, 1);
    end else begin
      check_eq("mem_err", mem_err[u], hang);
      if (hang) check_eq("to_cycles_in_range", (cyc >= TO && cyc <= TO + 2), 1);
      if (wstrb == 4'b0000) begin
        check_eq("mem_rdata", mem_rdata[u], hang ? 32'hDEAD_BEEF : rdata);
        if (!hang) check_eq("ready_one_after", cyc, rdy_cyc + 1);
      end else if (!hang) begin
        check_eq("beats_left", exp_q.size(), 0);
      end
    end
    mem_valid[u] = 1'b0;
    @(negedge clk);
    check_eq("ready_single_pulse", {mem_ready[u], mem_err[u], fa_valid[u], fa_lock[u]}, 0);
  endtask

  task automatic reset_mid(input int u);
    int beats, cyc;
    beats = 0;
    cyc   = 0;
    @(negedge clk);
    mem_valid[u] = 1'b1;
    mem_addr[u]  = 32'h0000_0200;
    mem_wdata[u] = $urandom;
    mem_wstrb[u] = 4'b0101;
    mem_instr[u] = 1'b0;
    while (cyc < 50 && beats < 2) begin
      fa_next[u] = 1'b0;
      if (fa_valid[u] && fa_write[u]) begin
        beats++;
        if (beats < 2) fa_next[u] = 1'b1;
      end
      if (beats < 2) begin
        @(negedge clk);
        cyc++;
      end
    end
    check_eq("rst_mid_second_beat", beats, 2);
    rst = 1'b1;
    #1;
    check_reset(u, "rst_mid");
    mem_valid[u] = 1'b0;
    fa_next[u]   = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] ws;
    for (int u = 0; u < 2; u++) begin
      mem_valid[u] = 1'b0; mem_instr[u] = 1'b0; mem_addr[u] = '0;
      mem_wdata[u] = '0;   mem_wstrb[u] = '0;
      fa_next[u]   = 1'b0; fa_rdata[u]  = '0;   fa_ready[u] = 1'b0;
    end
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_reset(0, "reset_be");
    check_reset(1, "reset_le");
    rst = 1'b0;
    @(negedge clk);

    for (int u = 0; u < 2; u++) begin
      run_txn(u, 32'h100, 32'h0, 4'b0000, 1'b1, 32'h1234_5678, 2, 1'b0, 0);
      run_txn(u, 32'h100, 32'hAABB_CCDD, 4'b1111, 1'b0, 32'h0, 0, 1'b0, 0);
      run_txn(u, 32'h100, 32'h1122_3344, 4'b1011, 1'b0, 32'h0, 0, 1'b0, 0);
      run_txn(u, 32'h103, 32'h0, 4'b0000, 1'b0, 32'h5555_AAAA, 1, 1'b1, 0);
      run_txn(u, 32'hFFFF_FFFE, 32'h0102_0304, 4'b0110, 1'b1, 32'h0, 0, 1'b0, 2);
      run_txn(u, 32'h40, 32'h0, 4'b0000, 1'b0, 32'hCAFE_F00D, 0, 1'b0, 1);
      reset_mid(u);
      run_txn(u, 32'h300, 32'h9988_7766, 4'b1100, 1'b0, 32'h0, 0, 1'b0, 0);
      for (int n = 0; n < 30; n++) begin
        ws = ($urandom_range(0, 3) == 0) ? 4'b0000 : 4'($urandom_range(1, 15));
        run_txn(u, $urandom, $urandom, ws, 1'($urandom_range(0, 1)), $urandom,
                $urandom_range(0, 3), 1'b0, ($urandom_range(0, 5) == 0) ? 2 : 0);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
